// File: rtl/seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner
//
// Multiplexed seven-segment display driver. A value is captured on load_i,
// optionally converted to BCD with a sequential double-dabble converter,
// and then committed atomically into the display registers that the scan
// logic walks through one digit at a time.
//
// Ports:
//   clk50m_i               system clock
//   rst_n_i                asynchronous active-low reset
//   value_i                value to display (DATA_W bits)
//   load_i                 one-cycle capture request for value/mode/blanking
//   mode_i                 0 = hex, 1 = unsigned decimal
//   blank_lz_i             1 = blank leading zeros
//   dp_i                   live decimal-point request per digit (bit 0 = right)
//   busy_o                 conversion or commit in progress
//   overflow_o             last committed value did not fit in DIGITS digits
//   seven_segment_o        registered segments {dp,g,f,e,d,c,b,a}
//   seven_segment_select_o registered one-hot digit select
// ---------------------------------------------------------------------------
module seven_segment_scanner #(
   parameter int DIGITS         = 4,
   parameter int DATA_W         = 16,
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1
) (
   input  logic              clk50m_i,
   input  logic              rst_n_i,
   input  logic [DATA_W-1:0] value_i,
   input  logic              load_i,
   input  logic              mode_i,
   input  logic              blank_lz_i,
   input  logic [DIGITS-1:0] dp_i,
   output logic              busy_o,
   output logic              overflow_o,
   output logic [7:0]        seven_segment_o,
   output logic [DIGITS-1:0] seven_segment_select_o
);

   // Nibble count: enough BCD digits for 2^DATA_W-1, enough hex digits for
   // DATA_W bits, and at least DIGITS so every display digit has a source.
   localparam int BCD_N  = (DATA_W * 30103 + 99999) / 100000 + 1;
   localparam int HEX_N  = (DATA_W + 3) / 4;
   localparam int NIBS_A = (BCD_N > HEX_N) ? BCD_N : HEX_N;
   localparam int NIBS   = (NIBS_A > DIGITS) ? NIBS_A : DIGITS;
   localparam int BCD_W  = NIBS * 4;
   localparam int CNT_W  = $clog2(REFRESH_DIV);
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int STEP_W = $clog2(DATA_W + 1);

   localparam logic [7:0]        SEG_IDLE = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

   state_t              state, state_next;
   logic                busy_q;
   logic                capture, dabble, commit;
   logic [DATA_W-1:0]   shift_q;
   logic [BCD_W-1:0]    bcd_q, bcd_adj, bcd_step, hex_pad, src;
   logic [BCD_W:0]      bcd_shift;
   logic                unused_carry;
   logic [STEP_W-1:0]   step_q;
   logic                mode_q, blank_lz_q;
   logic [3:0]          digit_q [DIGITS];
   logic [DIGITS-1:0]   blank_q, blank_next;
   logic                overflow_q, ovf_next, zero_run;
   logic [CNT_W-1:0]    cnt_q;
   logic [IDX_W-1:0]    idx_q;
   logic [6:0]          pat;
   logic [7:0]          seg_hi, seg_next, seg_q;
   logic [DIGITS-1:0]   sel_onehot, sel_next, sel_q;

   // Active-high glyph {g,f,e,d,c,b,a} for one hex digit.
   function automatic logic [6:0] hex_font(input logic [3:0] d);
      case (d)
         4'h0: hex_font = 7'h3F;
         4'h1: hex_font = 7'h06;
         4'h2: hex_font = 7'h5B;
         4'h3: hex_font = 7'h4F;
         4'h4: hex_font = 7'h66;
         4'h5: hex_font = 7'h6D;
         4'h6: hex_font = 7'h7D;
         4'h7: hex_font = 7'h07;
         4'h8: hex_font = 7'h7F;
         4'h9: hex_font = 7'h6F;
         4'hA: hex_font = 7'h77;
         4'hB: hex_font = 7'h7C;
         4'hC: hex_font = 7'h39;
         4'hD: hex_font = 7'h5E;
         4'hE: hex_font = 7'h79;
         default: hex_font = 7'h71;
      endcase
   endfunction

   // State register. busy is registered from the next state so it lines up
   // exactly with the cycles spent outside IDLE.
   always_ff @(posedge clk50m_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= IDLE;
         busy_q <= 1'b0;
      end else begin
         state  <= state_next;
         busy_q <= (state_next != IDLE);
      end
   end

   // Next-state logic. Hex values need no conversion and go straight to the
   // commit; decimal values spend one cycle per input bit in CONVERT.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (load_i) state_next = mode_i ? CONVERT : COMMIT;
         CONVERT: if (step_q == STEP_W'(1)) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs. Loads are only accepted in IDLE, so a request arriving
   // while busy simply disappears.
   always_comb begin
      capture = (state == IDLE) && load_i;
      dabble  = (state == CONVERT);
      commit  = (state == COMMIT);
   end

   // One double-dabble step: correct every nibble >= 5 by adding 3, then
   // shift the whole BCD register left, pulling in the binary MSB. The bit
   // shifted out of the top can never be set because the register is sized
   // for the largest possible value.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NIBS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_shift = {bcd_adj, shift_q[DATA_W-1]};
      bcd_step  = bcd_shift[BCD_W-1:0];
   end
   assign unused_carry = bcd_shift[BCD_W];

   // Capture and conversion datapath. In hex mode shift_q keeps the raw
   // value untouched until the commit reads it.
   always_ff @(posedge clk50m_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         shift_q    <= '0;
         bcd_q      <= '0;
         step_q     <= '0;
         mode_q     <= 1'b0;
         blank_lz_q <= 1'b0;
      end else if (capture) begin
         shift_q    <= value_i;
         bcd_q      <= '0;
         step_q     <= STEP_W'(DATA_W);
         mode_q     <= mode_i;
         blank_lz_q <= blank_lz_i;
      end else if (dabble) begin
         shift_q <= {shift_q[DATA_W-2:0], 1'b0};
         bcd_q   <= bcd_step;
         step_q  <= step_q - STEP_W'(1);
      end
   end

   // Commit preparation. Hex and BCD are both viewed as a nibble vector so
   // overflow is simply "any nibble beyond the displayed ones is nonzero".
   // Leading-zero blanking walks down from the top digit and stops at the
   // first nonzero nibble; the rightmost digit always stays visible.
   always_comb begin
      hex_pad              = '0;
      hex_pad[DATA_W-1:0]  = shift_q;
      src                  = mode_q ? bcd_q : hex_pad;
      ovf_next             = 1'b0;
      for (int i = DIGITS; i < NIBS; i++) begin
         ovf_next = ovf_next | (src[4*i +: 4] != 4'd0);
      end
      zero_run   = 1'b1;
      blank_next = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run      = zero_run & (src[4*i +: 4] == 4'd0);
         blank_next[i] = blank_lz_q & zero_run;
      end
   end

   // Display registers, all written in the same cycle so the scan never
   // sees a half-updated value.
   always_ff @(posedge clk50m_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DIGITS; i++) digit_q[i] <= 4'd0;
         blank_q    <= '0;
         overflow_q <= 1'b0;
      end else if (commit) begin
         for (int i = 0; i < DIGITS; i++) digit_q[i] <= src[4*i +: 4];
         blank_q    <= blank_next;
         overflow_q <= ovf_next;
      end
   end

   // Free-running refresh counter; each wrap moves the scan to the next digit.
   always_ff @(posedge clk50m_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_q <= '0;
         idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // Glyph for the digit currently being scanned. Overflow overrides both
   // the digit value and blanking with a dash; the decimal point stays live.
   always_comb begin
      if (overflow_q)          pat = 7'h40;
      else if (blank_q[idx_q]) pat = 7'h00;
      else                     pat = hex_font(digit_q[idx_q]);
      seg_hi     = {dp_i[idx_q], pat};
      seg_next   = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      sel_onehot = DIGITS'(1) << idx_q;
      sel_next   = SEL_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
   end

   // Output registers, refreshed every cycle from the current scan index.
   always_ff @(posedge clk50m_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         seg_q <= SEG_IDLE;
         sel_q <= SEL_IDLE;
      end else begin
         seg_q <= seg_next;
         sel_q <= sel_next;
      end
   end

   assign busy_o                 = busy_q;
   assign overflow_o             = overflow_q;
   assign seven_segment_o        = seg_q;
   assign seven_segment_select_o = sel_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Scoreboard bench for seven_segment_scanner (4 digits, 16-bit values,
// refresh every 4 cycles, active-low segments and selects). Each load pushes
// its expected busy length, overflow flag and four digit bytes; a monitor
// notices the end of each busy period, pops the expectation and checks the
// scanned digits.
// ---------------------------------------------------------------------------
module tb_seven_segment_scanner;

   localparam int DIGITS      = 4;
   localparam int DATA_W      = 16;
   localparam int REFRESH_DIV = 4;

   logic              clk50m_i;
   logic              rst_n_i;
   logic [DATA_W-1:0] value_i;
   logic              load_i;
   logic              mode_i;
   logic              blank_lz_i;
   logic [DIGITS-1:0] dp_i;
   logic              busy_o;
   logic              overflow_o;
   logic [7:0]        seven_segment_o;
   logic [DIGITS-1:0] seven_segment_select_o;

   typedef struct {
      string       name;
      int          busy_cycles;
      logic        ovf;
      logic [31:0] segs;
   } exp_t;

   exp_t sb_q[$];
   int   checks_total;
   int   checks_passed;
   int   mon_done;

   seven_segment_scanner #(
      .DIGITS(DIGITS),
      .DATA_W(DATA_W),
      .REFRESH_DIV(REFRESH_DIV),
      .SEG_ACTIVE_LOW(1'b1),
      .SEL_ACTIVE_LOW(1'b1)
   ) dut (
      .clk50m_i(clk50m_i),
      .rst_n_i(rst_n_i),
      .value_i(value_i),
      .load_i(load_i),
      .mode_i(mode_i),
      .blank_lz_i(blank_lz_i),
      .dp_i(dp_i),
      .busy_o(busy_o),
      .overflow_o(overflow_o),
      .seven_segment_o(seven_segment_o),
      .seven_segment_select_o(seven_segment_select_o)
   );

   // 10 time-unit clock, first rising edge at t=5
   initial begin
      clk50m_i = 1'b0;
      forever #5 clk50m_i = ~clk50m_i;
   end

   // Single comparison point: steps both counters, reports mismatches
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // Expired wait bound counts as a failed comparison
   task automatic timeoutFail(input string name);
      checks_total++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   // Walk one full scan rotation and compare each digit byte.
   // The extra rising edge skips the output update that still shows the
   // pre-commit display.
   task automatic scanDigits(input string name, input logic [31:0] segs);
      @(posedge clk50m_i);
      for (int d = 0; d < DIGITS; d++) begin
         logic [3:0] want_sel;
         int         waited;
         want_sel = ~(4'b0001 << d);
         waited   = 0;
         @(negedge clk50m_i);
         while (seven_segment_select_o !== want_sel && waited < 40) begin
            @(negedge clk50m_i);
            waited++;
         end
         if (seven_segment_select_o !== want_sel)
            timeoutFail($sformatf("%s select%0d", name, d));
         else
            checkOutput($sformatf("%s digit%0d", name, d), {24'd0, seven_segment_o}, {24'd0, segs[8*d +: 8]});
      end
   endtask

   // Queue the expected outcome of the next accepted load
   task automatic pushExpect(input string name, input int busy_cycles, input logic ovf, input logic [31:0] segs);
      exp_t e;
      e.name        = name;
      e.busy_cycles = busy_cycles;
      e.ovf         = ovf;
      e.segs        = segs;
      sb_q.push_back(e);
   endtask

   // One-cycle load pulse, driven between rising edges
   task automatic applyStimulus(input logic [DATA_W-1:0] v, input logic m, input logic b);
      @(negedge clk50m_i);
      value_i    = v;
      mode_i     = m;
      blank_lz_i = b;
      load_i     = 1'b1;
      @(negedge clk50m_i);
      load_i     = 1'b0;
   endtask

   // Block until the monitor has finished the given number of transactions
   task automatic waitDone(input int target, input string name);
      int waited;
      waited = 0;
      while (mon_done < target && waited < 400) begin
         @(negedge clk50m_i);
         waited++;
      end
      if (mon_done < target) timeoutFail({name, " completion"});
   endtask

   // Monitor: measures each busy period, then checks it against the
   // oldest queued expectation. Reset discards a partial busy period.
   initial begin
      int   run;
      exp_t e;
      run = 0;
      forever begin
         @(negedge clk50m_i);
         if (rst_n_i !== 1'b1) begin
            run = 0;
         end else if (busy_o === 1'b1) begin
            run++;
         end else if (run > 0) begin
            if (sb_q.size() == 0) begin
               timeoutFail("unexpected commit (no queued expectation)");
            end else begin
               e = sb_q.pop_front();
               checkOutput({e.name, " busy cycles"}, run, e.busy_cycles);
               checkOutput({e.name, " overflow"}, {31'd0, overflow_o}, {31'd0, e.ovf});
               scanDigits(e.name, e.segs);
            end
            run = 0;
            mon_done++;
         end
      end
   end

   // Directed stimulus sequence
   initial begin
      int target;
      checks_total  = 0;
      checks_passed = 0;
      mon_done      = 0;
      rst_n_i       = 1'b0;
      value_i       = '0;
      load_i        = 1'b0;
      mode_i        = 1'b0;
      blank_lz_i    = 1'b0;
      dp_i          = '0;

      // Reset state and first scan rotation
      repeat (3) @(negedge clk50m_i);
      checkOutput("reset seg", {24'd0, seven_segment_o}, 32'hFF);
      checkOutput("reset select", {28'd0, seven_segment_select_o}, 32'hF);
      checkOutput("reset busy", {31'd0, busy_o}, 32'd0);
      checkOutput("reset overflow", {31'd0, overflow_o}, 32'd0);
      rst_n_i = 1'b1;
      @(posedge clk50m_i); #1;
      checkOutput("first select", {28'd0, seven_segment_select_o}, 32'hE);
      checkOutput("first seg", {24'd0, seven_segment_o}, 32'hC0);
      repeat (REFRESH_DIV) @(posedge clk50m_i); #1;
      checkOutput("second select", {28'd0, seven_segment_select_o}, 32'hD);
      repeat (REFRESH_DIV) @(posedge clk50m_i); #1;
      checkOutput("third select", {28'd0, seven_segment_select_o}, 32'hB);

      // Hex 12AB with decimal point on digit 2 (A4 -> 24)
      dp_i   = 4'b0100;
      target = mon_done + 1;
      pushExpect("hex 12AB dp2", 1, 1'b0, 32'hF9248883);
      applyStimulus(16'h12AB, 1'b0, 1'b0);
      waitDone(target, "hex 12AB");
      dp_i = 4'b0000;

      // Decimal 1234
      target = mon_done + 1;
      pushExpect("dec 1234", 17, 1'b0, 32'hF9A4B099);
      applyStimulus(16'd1234, 1'b1, 1'b0);
      waitDone(target, "dec 1234");

      // Decimal 10000 overflows four digits
      target = mon_done + 1;
      pushExpect("dec 10000", 17, 1'b1, 32'hBFBFBFBF);
      applyStimulus(16'd10000, 1'b1, 1'b0);
      waitDone(target, "dec 10000");

      // Asynchronous reset mid-run clears everything at once
      @(negedge clk50m_i); #2;
      rst_n_i = 1'b0;
      #1;
      checkOutput("async reset seg", {24'd0, seven_segment_o}, 32'hFF);
      checkOutput("async reset select", {28'd0, seven_segment_select_o}, 32'hF);
      checkOutput("async reset busy", {31'd0, busy_o}, 32'd0);
      checkOutput("async reset overflow", {31'd0, overflow_o}, 32'd0);
      repeat (2) @(negedge clk50m_i);
      rst_n_i = 1'b1;

      // Hex FFFF fits in four digits
      target = mon_done + 1;
      pushExpect("hex FFFF", 1, 1'b0, 32'h8E8E8E8E);
      applyStimulus(16'hFFFF, 1'b0, 1'b0);
      waitDone(target, "hex FFFF");

      // Leading-zero blanking
      target = mon_done + 1;
      pushExpect("dec 7 blank", 17, 1'b0, 32'hFFFFFFF8);
      applyStimulus(16'd7, 1'b1, 1'b1);
      waitDone(target, "dec 7 blank");

      target = mon_done + 1;
      pushExpect("dec 0 blank", 17, 1'b0, 32'hFFFFFFC0);
      applyStimulus(16'd0, 1'b1, 1'b1);
      waitDone(target, "dec 0 blank");

      // Load during conversion is ignored
      target = mon_done + 1;
      pushExpect("dec 42 ignore", 17, 1'b0, 32'hC0C099A4);
      applyStimulus(16'd42, 1'b1, 1'b0);
      repeat (4) @(negedge clk50m_i);
      value_i = 16'h9999;
      mode_i  = 1'b0;
      load_i  = 1'b1;
      @(negedge clk50m_i);
      load_i  = 1'b0;
      waitDone(target, "dec 42 ignore");

      // Reset during conversion aborts without commit; display returns to 0
      applyStimulus(16'd555, 1'b1, 1'b0);
      repeat (5) @(negedge clk50m_i); #2;
      rst_n_i = 1'b0;
      #1;
      checkOutput("abort busy", {31'd0, busy_o}, 32'd0);
      repeat (2) @(negedge clk50m_i);
      rst_n_i = 1'b1;
      scanDigits("abort", 32'hC0C0C0C0);
      checkOutput("abort overflow", {31'd0, overflow_o}, 32'd0);
      repeat (30) @(negedge clk50m_i);
      checkOutput("scoreboard drained", sb_q.size(), 32'd0);

      $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised multiplexed seven-segment display driver. It is the successor to the fixed 4-digit hex-only score display, and adds:
- configurable digit count and input width
- a hex or decimal display mode, with a sequential binary-to-BCD converter
- leading-zero blanking
- overflow indication

It sits between game/score logic and the board's segment/digit-select pins. It is clocked from clk50m_i.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
DATA_W, 16, width of value_i (4..32)
REFRESH_DIV, 50000, clock cycles each digit stays selected (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment lines active low
SEL_ACTIVE_LOW, 1, 1 = digit select lines active low

Ports:
clk50m_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
value_i  input  DATA_W  value to display
load_i  input  1  one-cycle request to capture value_i, mode_i, blank_lz_i
mode_i  input  1  0 = hex, 1 = unsigned decimal
blank_lz_i  input  1  1 = blank leading zeros
dp_i  input  DIGITS  decimal-point request per digit (bit 0 = rightmost), live
busy_o  output  1  conversion/commit in progress
overflow_o  output  1  last committed value did not fit in DIGITS digits
seven_segment_o  output  8  segments {dp,g,f,e,d,c,b,a}, registered
seven_segment_select_o  output  DIGITS  one-hot digit select, registered

Behaviour:
- Reset is asynchronous and active low. While rst_n_i=0:
  - FSM=IDLE, busy_o=0, overflow_o=0.
  - Display digit regs = 0, blank flags = 0.
  - Scan counter = 0, digit index = 0.
  - seven_segment_o all inactive (8'hFF when SEG_ACTIVE_LOW).
  - seven_segment_select_o all inactive.
  - Reset mid-conversion aborts with no commit.
- FSM states are IDLE, CONVERT, COMMIT. busy_o = (state != IDLE), registered.
- IDLE, load_i=1 on edge T:
  - Capture value_i, mode_i and blank_lz_i.
  - Hex: go to COMMIT (busy_o high 1 cycle).
  - Decimal: clear the BCD shift register, go to CONVERT with step counter = DATA_W.
- CONVERT: one double-dabble step per cycle. Each step adds 3 to every BCD nibble that is >=5, then shifts left one bit, taking the binary MSB in. After DATA_W steps, go to COMMIT. busy_o is high for DATA_W+1 cycles in total.
- BCD register width: enough nibbles for 2^DATA_W-1, i.e. ceil(DATA_W*0.30103)+1 nibbles max.
- COMMIT: write all display regs and overflow_o atomically, then return to IDLE. The scanned display never shows a partially updated value.
- load_i is ignored while busy_o=1; no queueing.
- Overflow detection:
  - Hex: any value bit at index >= 4*DIGITS is set.
  - Decimal: any BCD nibble at index >= DIGITS is nonzero.
- On overflow, every digit shows a dash (segment g only), blanking is not applied, and dp_i is still honoured.
- Leading-zero blanking (blank_lz_i captured as 1): a digit is blank when it and every higher digit are 0. Digit 0 is never blanked.
- Scan:
  - The counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances 0→1→…→DIGITS-1→0.
  - Outputs are registered from the current index, so a select change occurs exactly every REFRESH_DIV cycles.
  - The first select (digit 0) appears on the first edge after reset release.
- Segment encoding, active-low a..g with dp off:
  0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E, dash BF, blank FF.
  - dp (bit 7) is driven from dp_i[index], sampled live.
  - With SEG_ACTIVE_LOW=0 the whole byte is inverted.
  - With SEL_ACTIVE_LOW=1 the select is ~onehot(index).
- Simultaneous load_i and scan wrap are independent. A commit landing on the same edge as a wrap is visible from the next output register update.

Test Plan (DIGITS=4, DATA_W=16, REFRESH_DIV=4, both active-low):
1. Reset asserted mid-run → seven_segment_o=8'hFF, select=4'hF, busy_o=0, overflow_o=0 immediately (asynchronous). After release, select=4'b1110 one edge later and rotates every 4 cycles.
2. Hex load 16'h12AB, blank_lz=0 → busy_o high exactly 1 cycle. Digits 0..3 show 83, 88, A4, F9; dp_i=4'b0100 clears bit 7 only while select=4'b1011.
3. Decimal load 16'd1234 → busy_o high exactly 17 cycles. Then digits 0..3 show 99, B0, A4, F9, overflow_o=0.
4. Decimal load 16'd10000 → overflow_o=1, all digits BF. Then hex load 16'hFFFF → overflow_o=0, all digits 8E.
5. Decimal 16'd7 with blank_lz=1 → digit0 F8, digits1–3 FF. Value 0 → digit0 C0, others FF.
6. load_i pulsed 5 cycles into a decimal conversion of 16'd42 → ignored, result 42 shown. Separately, rst_n_i dropped during CONVERT → no commit, display remains 0.
